// File: rtl/traffic_control.sv
// traffic_control: four-way intersection light controller.
//
// Normal rotation is N -> S -> E -> W -> N, each direction showing green for
// GREEN_CYCLES then yellow for YELLOW_CYCLES; every other direction is red.
// A latched emergency request cuts short a foreign green, lets any yellow
// finish, then holds the requested direction green for EMERG_CYCLES.
//
// Optional feature macro: TRAFFIC_PED_EN
//   defined   : pedestrian button latches a request that is served as an
//               all-red PED_WALK phase after the next yellow completes.
//   undefined : ped_request is ignored and there is no PED_WALK phase.
//
// Ports:
//   clk            single clock, rising edge
//   rst_a          synchronous active-high reset
//   ped_request    pedestrian button, sampled every rising edge
//   emergency_dir  emergency presence, bit0 N, bit1 S, bit2 E, bit3 W
//   n/s/e/w_lights {green,yellow,red}: 100 green, 010 yellow, 001 red
module traffic_control #(
    parameter int GREEN_CYCLES  = 8,
    parameter int YELLOW_CYCLES = 2,
    parameter int PED_CYCLES    = 5,
    parameter int EMERG_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       ped_request,
    input  logic [3:0] emergency_dir,
    output logic [2:0] n_lights,
    output logic [2:0] s_lights,
    output logic [2:0] e_lights,
    output logic [2:0] w_lights
);

    localparam int MAX_GY  = (GREEN_CYCLES > YELLOW_CYCLES) ? GREEN_CYCLES : YELLOW_CYCLES;
    localparam int MAX_PE  = (PED_CYCLES > EMERG_CYCLES) ? PED_CYCLES : EMERG_CYCLES;
    localparam int MAX_CYC = (MAX_GY > MAX_PE) ? MAX_GY : MAX_PE;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [2:0] LIGHT_G = 3'b100;
    localparam logic [2:0] LIGHT_Y = 3'b010;
    localparam logic [2:0] LIGHT_R = 3'b001;

    // Green/yellow encodings are {0, dir[1:0], is_yellow} so the direction
    // and colour fall straight out of the state bits.
    typedef enum logic [3:0] {
        N_GREEN  = 4'd0,
        N_YELLOW = 4'd1,
        S_GREEN  = 4'd2,
        S_YELLOW = 4'd3,
        E_GREEN  = 4'd4,
        E_YELLOW = 4'd5,
        W_GREEN  = 4'd6,
        W_YELLOW = 4'd7,
`ifdef TRAFFIC_PED_EN
        PED_WALK = 4'd8,
`endif
        EMERG    = 4'd9
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             emerg_pend;
    logic [1:0]       emerg_idx;    // kept after the latch clears; EMERG decodes it
    logic [1:0]       next_dir;

`ifdef TRAFFIC_PED_EN
    logic             ped_pending;
    logic [1:0]       ped_next;     // direction whose green follows the walk
`else
    logic             ped_unused;
    assign ped_unused = ped_request;
`endif

    function automatic state_t green_of(input logic [1:0] d);
        return state_t'({1'b0, d, 1'b0});
    endfunction

    function automatic state_t yellow_of(input logic [1:0] d);
        return state_t'({1'b0, d, 1'b1});
    endfunction

    // Fixed priority N > S > E > W; lower-priority bits are dropped.
    function automatic logic [1:0] emerg_prio(input logic [3:0] d);
        if (d[0])      return 2'd0;
        else if (d[1]) return 2'd1;
        else if (d[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    assign next_dir = state[2:1] + 2'd1;

    always_ff @(posedge clk) begin
        if (rst_a) begin
            state      <= N_GREEN;
            cnt        <= CNT_W'(GREEN_CYCLES);
            emerg_pend <= 1'b0;
            emerg_idx  <= 2'd0;
`ifdef TRAFFIC_PED_EN
            ped_pending <= 1'b0;
            ped_next    <= 2'd0;
`endif
        end else begin
            if (state != EMERG && !emerg_pend && emergency_dir != 4'd0) begin
                emerg_pend <= 1'b1;
                emerg_idx  <= emerg_prio(emergency_dir);
            end
`ifdef TRAFFIC_PED_EN
            if (state != PED_WALK && ped_request)
                ped_pending <= 1'b1;
`endif
            cnt <= cnt - 1'b1;

            case (state)
                N_GREEN, S_GREEN, E_GREEN, W_GREEN: begin
                    // A same-direction emergency keeps the green lit and
                    // converts it to EMERG without a yellow in between.
                    if (emerg_pend && emerg_idx == state[2:1]) begin
                        state      <= EMERG;
                        cnt        <= CNT_W'(EMERG_CYCLES);
                        emerg_pend <= 1'b0;
                    end else if (emerg_pend || cnt == CNT_W'(1)) begin
                        state <= yellow_of(state[2:1]);
                        cnt   <= CNT_W'(YELLOW_CYCLES);
                    end
                end
                N_YELLOW, S_YELLOW, E_YELLOW, W_YELLOW: begin
                    if (cnt == CNT_W'(1)) begin
                        if (emerg_pend) begin
                            state      <= EMERG;
                            cnt        <= CNT_W'(EMERG_CYCLES);
                            emerg_pend <= 1'b0;
`ifdef TRAFFIC_PED_EN
                        end else if (ped_pending) begin
                            state       <= PED_WALK;
                            cnt         <= CNT_W'(PED_CYCLES);
                            ped_pending <= 1'b0;
                            ped_next    <= next_dir;
`endif
                        end else begin
                            state <= green_of(next_dir);
                            cnt   <= CNT_W'(GREEN_CYCLES);
                        end
                    end
                end
`ifdef TRAFFIC_PED_EN
                PED_WALK: begin
                    if (cnt == CNT_W'(1)) begin
                        if (emerg_pend) begin
                            state      <= EMERG;
                            cnt        <= CNT_W'(EMERG_CYCLES);
                            emerg_pend <= 1'b0;
                        end else begin
                            state <= green_of(ped_next);
                            cnt   <= CNT_W'(GREEN_CYCLES);
                        end
                    end
                end
`endif
                EMERG: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= yellow_of(emerg_idx);
                        cnt   <= CNT_W'(YELLOW_CYCLES);
                    end
                end
                default: begin
                    state <= N_GREEN;
                    cnt   <= CNT_W'(GREEN_CYCLES);
                end
            endcase
        end
    end

    // Light decode: at most one direction is ever selected.
    logic       act_en;
    logic [1:0] act_dir;
    logic [2:0] act_col;

    always_comb begin
        act_en  = 1'b0;
        act_dir = state[2:1];
        act_col = LIGHT_G;
        if (state == EMERG) begin
            act_en  = 1'b1;
            act_dir = emerg_idx;
        end else if (state <= W_YELLOW) begin
            act_en  = 1'b1;
            act_col = state[0] ? LIGHT_Y : LIGHT_G;
        end
        n_lights = (act_en && act_dir == 2'd0) ? act_col : LIGHT_R;
        s_lights = (act_en && act_dir == 2'd1) ? act_col : LIGHT_R;
        e_lights = (act_en && act_dir == 2'd2) ? act_col : LIGHT_R;
        w_lights = (act_en && act_dir == 2'd3) ? act_col : LIGHT_R;
    end

endmodule

// File: tb/tb_traffic_control.sv
// tb_traffic_control: directed bench for traffic_control at default
// parameters. Lights are compared as one 12-bit word {n,s,e,w}; expected
// words are built from the direction/colour the sequence should show.
// Pedestrian expectations follow the TRAFFIC_PED_EN macro of the build.
module tb_traffic_control;

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] R = 3'b001;

    logic       clk;
    logic       rst_a;
    logic       ped_request;
    logic [3:0] emergency_dir;
    logic [2:0] n_lights, s_lights, e_lights, w_lights;

    int errors = 0;
    int checks = 0;
    int pos    = 0;   // position in the 40-clock undisturbed rotation

    traffic_control dut (
        .clk           (clk),
        .rst_a         (rst_a),
        .ped_request   (ped_request),
        .emergency_dir (emergency_dir),
        .n_lights      (n_lights),
        .s_lights      (s_lights),
        .e_lights      (e_lights),
        .w_lights      (w_lights)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // d: 0 N, 1 S, 2 E, 3 W, -1 none (all red)
    function automatic logic [11:0] lights_of(input int d, input logic [2:0] c);
        logic [11:0] r;
        r = {R, R, R, R};
        if (d >= 0) r[(3 - d) * 3 +: 3] = c;
        return r;
    endfunction

    function automatic logic [11:0] rotation_at(input int p);
        return lights_of(p / 10, ((p % 10) < 8) ? G : Y);
    endfunction

    function automatic int nonred(input logic [11:0] l);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++)
            if (l[i * 3 +: 3] != R) n++;
        return n;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] expv);
        logic [11:0] obs;
        obs = {n_lights, s_lights, e_lights, w_lights};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed nswe=%b required nswe=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_one_active();
        int n;
        n = nonred({n_lights, s_lights, e_lights, w_lights});
        checks++;
        assert (n <= 1) else begin
            errors++;
            $error("FAIL one_active: observed %0d non-red directions, required at most 1", n);
        end
    endtask

    // Advance n clocks of undisturbed rotation, checking every cycle.
    task automatic run_rotation(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            pos = (pos + 1) % 40;
            chk("rotation", rotation_at(pos));
            chk_one_active();
        end
    endtask

    initial begin
        rst_a         = 1'b1;
        ped_request   = 1'b0;
        emergency_dir = 4'd0;

        // Reset for two cycles, then N green 8 clocks, N yellow 2, S green.
        cyc();
        cyc();
        chk("reset_state", lights_of(0, G));
        rst_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("first_n_green", lights_of(0, G));
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("first_n_yellow", lights_of(0, Y));
        end
        cyc();
        chk("first_s_green", lights_of(1, G));
        pos = 10;

        // One full undisturbed period returns to the start of S green.
        run_rotation(40);
        run_rotation(30);

        // One-cycle pedestrian request during N green.
        ped_request = 1'b1;
        cyc();
        chk("ped_n_green", lights_of(0, G));
        ped_request = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("ped_n_green", lights_of(0, G));
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("ped_n_yellow", lights_of(0, Y));
        end
`ifdef TRAFFIC_PED_EN
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ped_walk", lights_of(-1, R));
        end
`endif
        cyc();
        chk("ped_then_s_green", lights_of(1, G));
        pos = 10;
        run_rotation(30);

        // S emergency held 3 clocks during N green.
        emergency_dir = 4'b0010;
        cyc();
        chk("emerg_s_capture", lights_of(0, G));
        cyc();
        chk("emerg_s_n_yellow", lights_of(0, Y));
        cyc();
        chk("emerg_s_n_yellow", lights_of(0, Y));
        emergency_dir = 4'd0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("emerg_s_green", lights_of(1, G));
            chk_one_active();
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("emerg_s_yellow", lights_of(1, Y));
        end
        cyc();
        chk("emerg_s_then_e", lights_of(2, G));

        // E emergency during E green; an N request inside EMERG is ignored.
        emergency_dir = 4'b0100;
        cyc();
        chk("emerg_e_capture", lights_of(2, G));
        for (int i = 0; i < 10; i++) begin
            emergency_dir = (i == 2) ? 4'b0001 : 4'd0;
            cyc();
            chk("emerg_e_green", lights_of(2, G));
        end
        emergency_dir = 4'd0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("emerg_e_yellow", lights_of(2, Y));
        end
        cyc();
        chk("emerg_e_then_w", lights_of(3, G));
        pos = 30;
        run_rotation(10);

        // Emergency S/E plus pedestrian during N green; S wins, walk follows.
        emergency_dir = 4'b0110;
        ped_request   = 1'b1;
        cyc();
        chk("combo_capture", lights_of(0, G));
        emergency_dir = 4'd0;
        ped_request   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("combo_n_yellow", lights_of(0, Y));
        end
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("combo_s_emerg", lights_of(1, G));
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("combo_s_yellow", lights_of(1, Y));
        end
`ifdef TRAFFIC_PED_EN
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("combo_walk", lights_of(-1, R));
        end
`endif
        cyc();
        chk("combo_e_green", lights_of(2, G));

        // Reset in the middle of an EMERG phase.
        emergency_dir = 4'b0100;
        cyc();
        chk("reset_emerg_capture", lights_of(2, G));
        emergency_dir = 4'd0;
        cyc();
        cyc();
        chk("reset_emerg_active", lights_of(2, G));
        rst_a = 1'b1;
        cyc();
        chk("reset_mid_emerg", lights_of(0, G));
        rst_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cyc();
            chk("post_reset_n_green", lights_of(0, G));
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("post_reset_n_yellow", lights_of(0, Y));
        end
        cyc();
        chk("post_reset_s_green", lights_of(1, G));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
